// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//    Instruction-fetch program-counter sequencer.
//    - Issues one instruction-memory read per fetch.
//    - Presents the returned instruction to a consumer, which may stall it.
//    - Advances the PC by 4, or jumps to a branch/jump redirect target.
//
//    A redirect that arrives while a read is outstanding is remembered in a
//    pending register. When that read completes, its word is thrown away and
//    the fetch restarts at the redirect target.
//
// Parameters:
//    RESET_VECTOR  first fetch address after reset
//    EXC_VECTOR    target loaded when a redirect is misaligned
//                  (alignment-check build only)
//
// Ports:
//    Clk           single clock; all state changes on its rising edge
//    Reset         asynchronous, active-high reset
//    stall         consumer cannot accept the presented instruction
//    redir_valid   redirect request, one-cycle pulse
//    redir_target  redirect address
//    imem_req      instruction-memory read request
//    imem_addr     read address (equals pc)
//    imem_ack      read completes this cycle (ignored unless imem_req=1)
//    fetch_valid   instruction for fetch_pc is being presented
//    fetch_pc      address of the presented instruction
//    pc            current PC register value
//    misalign      one-cycle pulse flagging a misaligned redirect
//
// Configuration macro:
//    PC_ALIGN_CHECK_EN
//       Defined:   a redirect whose target has nonzero low two bits loads
//                  EXC_VECTOR instead, and pulses misalign for one cycle.
//       Undefined: the low two bits of a redirect target are cleared when it
//                  is loaded, and misalign is tied low.
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        stall,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] pc,
   output logic        misalign
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;

   // Candidate redirect address. A same-cycle request beats a pending one.
   logic [31:0] load_raw;
   logic [31:0] load_pc;
   logic        load_req;

   assign load_raw = redir_valid ? redir_target : pend_target_q;

`ifdef PC_ALIGN_CHECK_EN
   logic load_bad;
   logic misalign_q, misalign_d;

   // A misaligned target is replaced by the exception vector.
   always_comb begin
      load_bad = (load_raw[1:0] != 2'b00);
      load_pc  = load_bad ? EXC_VECTOR : load_raw;
   end
`else
   // Without checking, a target is forced onto a word boundary.
   always_comb begin
      load_pc = load_raw & ~32'd3;
   end
`endif

   // Next-state logic.
   // - load_req marks the cycles where pc takes the redirect address.
   // - The pending register only matters while a read is outstanding; it is
   //   cleared whenever a read completes.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      load_req      = 1'b0;

      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (redir_valid) begin
               pend_valid_d  = 1'b1;
               pend_target_d = redir_target;
            end
         end

         FETCH: begin
            if (imem_ack) begin
               pend_valid_d = 1'b0;
               if (redir_valid || pend_valid_q) begin
                  // The fetched word belongs to the old path; drop it.
                  load_req = 1'b1;
               end else begin
                  state_d = OUT;
               end
            end else if (redir_valid) begin
               pend_valid_d  = 1'b1;
               pend_target_d = redir_target;
            end
         end

         OUT: begin
            if (redir_valid) begin
               load_req = 1'b1;
               state_d  = FETCH;
            end else if (!stall) begin
               pc_d    = pc_q + 32'd4;
               state_d = FETCH;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (load_req) begin
         pc_d = load_pc;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   // The misalign pulse lines up with the cycle that pc shows EXC_VECTOR.
   always_comb begin
      misalign_d = load_req && load_bad;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   // Sequential state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_VECTOR;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   // Outputs are decoded from the state register only.
   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign fetch_valid = (state_q == OUT);
   assign fetch_pc    = pc_q;
   assign pc          = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Purpose:
//    Directed testbench for pc_sequencer using hand-computed expected values.
//    Inputs change on the falling clock edge, and outputs are observed there
//    too, before the inputs change. Each scenario runs from where the
//    previous one stopped.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        Clk;
   logic        Reset;
   logic        stall;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] pc;
   logic        misalign;

   int errors;
   int checks;

   pc_sequencer #(
      .RESET_VECTOR(32'h0000_0000),
      .EXC_VECTOR  (32'h8000_0180)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .stall       (stall),
      .redir_valid (redir_valid),
      .redir_target(redir_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .pc          (pc),
      .misalign    (misalign)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(negedge Clk);
   endtask

   // Reset is held from time zero, then released at a falling edge.
   task automatic test_reset();
      Reset = 1'b1; stall = 1'b0; redir_valid = 1'b0;
      redir_target = '0; imem_ack = 1'b0;
      tick(); tick();
      checks++;
      if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: req=%b valid=%b, required 0/0", imem_req, fetch_valid);
      end
      checks++;
      if (pc !== 32'h0 || fetch_pc !== 32'h0 || misalign !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_pc: pc=%h fetch_pc=%h mis=%b, required 0/0/0", pc, fetch_pc, misalign);
      end
      Reset = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("[TB] FAIL first_fetch: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
      end
   endtask

   // Zero-wait memory: FETCH and OUT alternate, and the PC advances by 4.
   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || fetch_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL seq_fetch%0d: req=%b addr=%h valid=%b, required 1/%h/0", i, imem_req, imem_addr, fetch_valid, 32'(4 * i));
         end
         imem_ack = 1'b1;
         tick();
         imem_ack = 1'b0;
         checks++;
         if (fetch_valid !== 1'b1 || fetch_pc !== 32'(4 * i) || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL seq_out%0d: valid=%b fetch_pc=%h req=%b, required 1/%h/0", i, fetch_valid, fetch_pc, imem_req, 32'(4 * i));
         end
         if (i < 2) tick();
      end
   endtask

   // Stall for three cycles while at OUT with pc=0x8.
   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (fetch_valid !== 1'b1 || fetch_pc !== 32'h8) begin
            errors++;
            $display("[TB] FAIL stall_hold%0d: valid=%b fetch_pc=%h, required 1/00000008", i, fetch_valid, fetch_pc);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hC || fetch_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_release: req=%b addr=%h valid=%b, required 1/0000000c/0", imem_req, imem_addr, fetch_valid);
      end
   endtask

   // A redirect during FETCH, with the ack arriving two cycles later.
   task automatic test_redirect_pending();
      redir_valid = 1'b1; redir_target = 32'h100;
      tick();
      redir_valid = 1'b0;
      checks++;
      if (imem_addr !== 32'hC || imem_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pend_wait: addr=%h req=%b, required 0000000c/1", imem_addr, imem_req);
      end
      tick();
      imem_ack = 1'b1;
      tick();
      checks++;
      if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         errors++;
         $display("[TB] FAIL pend_discard: valid=%b req=%b addr=%h, required 0/1/00000100", fetch_valid, imem_req, imem_addr);
      end
      tick();
      imem_ack = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100) begin
         errors++;
         $display("[TB] FAIL pend_out: valid=%b fetch_pc=%h, required 1/00000100", fetch_valid, fetch_pc);
      end
      tick();
   endtask

   // A redirect in the same cycle as the ack; the FETCH is at 0x104.
   task automatic test_redirect_same_cycle();
      checks++;
      if (imem_addr !== 32'h104) begin
         errors++;
         $display("[TB] FAIL same_pre: addr=%h, required 00000104", imem_addr);
      end
      imem_ack = 1'b1; redir_valid = 1'b1; redir_target = 32'h40;
      tick();
      redir_valid = 1'b0;
      checks++;
      if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         errors++;
         $display("[TB] FAIL same_redirect: valid=%b req=%b addr=%h, required 0/1/00000040", fetch_valid, imem_req, imem_addr);
      end
      tick();
      imem_ack = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'h40) begin
         errors++;
         $display("[TB] FAIL same_out: valid=%b fetch_pc=%h, required 1/00000040", fetch_valid, fetch_pc);
      end
   endtask

   // A misaligned redirect issued from OUT.
   task automatic test_misalign();
      logic [31:0] exp_pc;
      logic        exp_mis;
`ifdef PC_ALIGN_CHECK_EN
      exp_pc = 32'h8000_0180; exp_mis = 1'b1;
`else
      exp_pc = 32'h0000_0100; exp_mis = 1'b0;
`endif
      stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h102;
      tick();
      redir_valid = 1'b0; stall = 1'b0;
      checks++;
      if (pc !== exp_pc || misalign !== exp_mis || imem_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL misalign_load: pc=%h mis=%b req=%b, required %h/%b/1", pc, misalign, imem_req, exp_pc, exp_mis);
      end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (misalign !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== exp_pc) begin
         errors++;
         $display("[TB] FAIL misalign_pulse_end: mis=%b valid=%b fetch_pc=%h, required 0/1/%h", misalign, fetch_valid, fetch_pc, exp_pc);
      end
   endtask

   // pc 0xFFFF_FFFC increments to 0; then two redirects while waiting, where
   // the later one wins; stall is ignored during FETCH.
   task automatic test_wrap_and_latest();
      redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
      tick();
      redir_valid = 1'b0; imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("[TB] FAIL wrap_out: valid=%b fetch_pc=%h, required 1/fffffffc", fetch_valid, fetch_pc);
      end
      tick();
      checks++;
      if (pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("[TB] FAIL wrap_zero: pc=%h req=%b addr=%h, required 0/1/0", pc, imem_req, imem_addr);
      end
      redir_valid = 1'b1; redir_target = 32'h200; stall = 1'b1;
      tick();
      redir_target = 32'h300;
      tick();
      redir_valid = 1'b0; imem_ack = 1'b1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("[TB] FAIL stall_in_fetch: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
      end
      tick();
      checks++;
      if (imem_addr !== 32'h300 || fetch_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL latest_wins: addr=%h valid=%b, required 00000300/0", imem_addr, fetch_valid);
      end
      tick();
      imem_ack = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'h300) begin
         errors++;
         $display("[TB] FAIL latest_out: valid=%b fetch_pc=%h, required 1/00000300", fetch_valid, fetch_pc);
      end
      stall = 1'b0;
      tick();
   endtask

   // Reset pulsed mid-FETCH, then a late ack arrives in IDLE.
   task automatic test_reset_mid_fetch();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin
         errors++;
         $display("[TB] FAIL pre_reset: req=%b addr=%h, required 1/00000304", imem_req, imem_addr);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || pc !== 32'h0 || fetch_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: req=%b pc=%h valid=%b, required 0/0/0", imem_req, pc, fetch_valid);
      end
      tick();
      Reset = 1'b0; imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || fetch_valid !== 1'b0 || imem_addr !== 32'h0) begin
         errors++;
         $display("[TB] FAIL late_ack_ignored: req=%b valid=%b addr=%h, required 1/0/0", imem_req, fetch_valid, imem_addr);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_pending();
      test_redirect_same_cycle();
      test_misalign();
      test_wrap_and_latest();
      test_reset_mid_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h8000_0180, target used on misaligned redirect.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  consumer cannot accept the presented instruction.
REQ-006 SHALL have port redir_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-007 SHALL have port redir_target  input  32  redirect address.
REQ-008 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-009 SHALL have port imem_addr  output  32  read address, equal to pc while imem_req=1.
REQ-010 SHALL have port imem_ack  input  1  read completes this cycle; ignored when imem_req=0.
REQ-011 SHALL have port fetch_valid  output  1  instruction for fetch_pc is being presented.
REQ-012 SHALL have port fetch_pc  output  32  address of the presented instruction.
REQ-013 SHALL have port pc  output  32  current architectural PC register value.
REQ-014 SHALL have port misalign  output  1  one-cycle pulse flagging a misaligned redirect.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, OUT; all outputs registered or decoded from state only.
REQ-016 IDLE: imem_req=0, fetch_valid=0; next cycle unconditionally -> FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc; waits any number of cycles for imem_ack.
REQ-018 FETCH, imem_ack=1, no redirect pending and redir_valid=0 -> OUT; pc unchanged.
REQ-019 FETCH, redir_valid=1 without imem_ack: latch target into pending register; a later redir_valid overwrites it (latest wins).
REQ-020 FETCH, imem_ack=1 with pending or same-cycle redirect: fetched word discarded (no OUT), pc <= redirect target (same-cycle redir_valid beats pending), pending cleared, remain FETCH.
REQ-021 OUT: fetch_valid=1, fetch_pc=pc, imem_req=0.
REQ-022 OUT, redir_valid=1: pc <= target, -> FETCH, regardless of stall.
REQ-023 OUT, redir_valid=0, stall=0: pc <= pc + 32'd4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), -> FETCH.
REQ-024 OUT, redir_valid=0, stall=1: hold state, pc and fetch_pc unchanged.
REQ-025 stall SHALL have no effect in IDLE or FETCH.
REQ-026 Throughput with zero-wait memory and no stall: one instruction per 2 cycles.

Reset
REQ-027 Reset=1 SHALL immediately force state=IDLE, pc=RESET_VECTOR, pending cleared, imem_req=0, fetch_valid=0, fetch_pc=RESET_VECTOR, misalign=0.
REQ-028 Reset asserted mid-FETCH SHALL drop the outstanding request; a late imem_ack after reset release in IDLE SHALL be ignored.

Configuration
REQ-029 Macro PC_ALIGN_CHECK_EN defined: redirect with target[1:0]!=2'b00 SHALL load pc=EXC_VECTOR instead of target and pulse misalign for one cycle at the cycle pc is loaded.
REQ-030 Macro PC_ALIGN_CHECK_EN undefined: target[1:0] SHALL be forced to 2'b00 when loaded; misalign tied to 0.

Verification
REQ-031 Reset release, imem_ack one cycle after each req, stall=0 -> fetch_pc sequence 0x0,0x4,0x8, fetch_valid every 2nd cycle.
REQ-032 stall=1 for 3 cycles in OUT at pc=0x8 -> fetch_valid held 3 extra cycles, fetch_pc=0x8, next imem_addr=0xC.
REQ-033 redir_valid target 0x100 during FETCH with ack 2 cycles later -> that fetch discarded, next imem_addr=0x100, first fetch_pc=0x100.
REQ-034 redir_valid and imem_ack same cycle, target 0x40 -> no fetch_valid, imem_addr=0x40 next cycle.
REQ-035 With PC_ALIGN_CHECK_EN, redirect to 0x102 -> pc=0x8000_0180, misalign one cycle; without macro -> pc=0x100, misalign=0.
REQ-036 pc=0xFFFF_FFFC, OUT, stall=0 -> pc=0x0; Reset pulsed mid-FETCH -> pc=RESET_VECTOR, imem_req=0 same cycle.
